imem_program_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 14 +
 rtl/imem_program_loader.sv | 139 +++++++++++++
 tb/tb_imem_program_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake and IMEM write port of the program loader.
interface imem_loader_if #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [7:0]             Byte_In;
    logic                   Byte_Valid;
    logic                   Byte_Ready;
    logic                   IMEM_We;
    logic [PC_WIDTH-1:0]    IMEM_Addr;
    logic [INSTR_WIDTH-1:0] IMEM_Wdata;
    modport master (input Byte_In, Byte_Valid, output Byte_Ready, IMEM_We, IMEM_Addr, IMEM_Wdata);
    modport slave (output Byte_In, Byte_Valid, input Byte_Ready, IMEM_We, IMEM_Addr, IMEM_Wdata);
endinterface

// File: rtl/imem_program_loader.sv
// imem_program_loader: boot loader streaming a length-prefixed image into IMEM while stalling the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit additive checksum after the words.
module imem_program_loader #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int IMEM_DEPTH  = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        Load_Start,
    imem_loader_if.master               bus,
    output logic                        CPU_Hold,
    output logic                        Load_Done,
    output logic                        Load_Error,
    output logic [$clog2(IMEM_DEPTH):0] Words_Loaded
);
    localparam int CW = $clog2(IMEM_DEPTH) + 1;
    typedef enum logic [2:0] {
        IDLE, LEN, DATA, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE, ERR
    } state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif
    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [31:0]            shift_q, shift_d, word;
    logic [CW-1:0]          len_q, len_d, idx_q, idx_d;
    logic                   ready_q, ready_d, we_q, we_d, hold_q, hold_d;
    logic                   done_q, done_d, err_q, err_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   take, last;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]            sum_q, sum_d;
`endif
    assign take = bus.Byte_Valid && ready_q;
    assign last = take && cnt_q == 2'd3;
    // bytes arrive LSB first, so each new byte enters at the top
    assign word = {bus.Byte_In, shift_q[31:8]};
    always_comb begin
        state_d = state_q;
        cnt_d   = take ? cnt_q + 2'd1 : cnt_q;
        shift_d = take ? word : shift_q;
        len_d   = len_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            LEN: if (last) begin
                len_d   = word[CW-1:0];
                state_d = word > 32'(IMEM_DEPTH) ? ERR : word == 32'd0 ? FIN : DATA;
            end
            DATA: if (last) begin
                state_d = WRITE;
                we_d    = 1'b1;
                addr_d  = PC_WIDTH'(idx_q) << 2;
                wdata_d = word;
            end
            WRITE: begin
                idx_d   = idx_q + CW'(1);
                state_d = idx_q + CW'(1) < len_q ? DATA : FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d   = sum_q + wdata_q;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: if (last) state_d = word == sum_q ? DONE : ERR;
`endif
            default: if (Load_Start) begin
                state_d = LEN;
                cnt_d   = 2'd0;
                idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
        endcase
        ready_d = state_d == LEN || state_d == DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready_d = ready_d || state_d == CSUM;
`endif
        hold_d  = state_d != IDLE && state_d != DONE;
        done_d  = state_d == DONE;
        err_d   = state_d == ERR;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            shift_q <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
    assign bus.Byte_Ready = ready_q;
    assign bus.IMEM_We    = we_q;
    assign bus.IMEM_Addr  = addr_q;
    assign bus.IMEM_Wdata = wdata_q;
    assign CPU_Hold       = hold_q;
    assign Load_Done      = done_q;
    assign Load_Error     = err_q;
    assign Words_Loaded   = idx_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed checks of the loader with a 16-word IMEM.
module tb_imem_program_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        cpu_hold, load_done, load_error;
    logic [4:0]  words_loaded;
    logic [31:0] img [16];
    logic [31:0] mem [16];
    logic [31:0] log_addr [256];
    logic [31:0] log_data [256];
    int          we_cnt = 0;
    int          rdy_viol = 0;
    int          total = 0;
    int          bad = 0;
    int          lat;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] cs_adj = 32'd0;
`endif

    imem_loader_if #(.PC_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    imem_program_loader #(.PC_WIDTH(32), .INSTR_WIDTH(32), .IMEM_DEPTH(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Load_Start   (load_start),
        .bus          (bus.master),
        .CPU_Hold     (cpu_hold),
        .Load_Done    (load_done),
        .Load_Error   (load_error),
        .Words_Loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // IMEM model and write logger
    always @(negedge clk) begin
        if (bus.IMEM_We === 1'b1) begin
            log_addr[we_cnt] = bus.IMEM_Addr;
            log_data[we_cnt] = bus.IMEM_Wdata;
            mem[bus.IMEM_Addr[5:2]] = bus.IMEM_Wdata;
            if (bus.Byte_Ready !== 1'b0) rdy_viol++;
            we_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g = 0;
        while (gaps && $urandom_range(0, 2) == 0) begin
            bus.Byte_Valid = 1'b0;
            @(negedge clk);
        end
        bus.Byte_In = b;
        bus.Byte_Valid = 1'b1;
        while (bus.Byte_Ready !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) begin
            total++;
            bad++;
            $display("FAIL byte_accept: Byte_Ready=%b, required 1 within 40 cycles", bus.Byte_Ready);
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        total++;
        if ({bus.Byte_Ready, cpu_hold, load_done, load_error, words_loaded} !== 9'b1100_00000) begin
            bad++;
            $display("FAIL start_t1: rdy/hold/done/err/wl=%b, required 110000000",
                     {bus.Byte_Ready, cpu_hold, load_done, load_error, words_loaded});
        end
    endtask

    task automatic load(input logic [31:0] n, input int nw, input bit gaps, output int l);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [31:0] s = 32'd0;
`endif
        start_load();
        send_word(n, gaps);
        for (int i = 0; i < nw; i++) send_word(img[i], gaps);
`ifdef IMEM_LOADER_CHECKSUM_EN
        for (int i = 0; i < nw; i++) s = s + img[i];
        if (n <= 32'd16) send_word(s + cs_adj, gaps);
`endif
        bus.Byte_Valid = 1'b0;
        l = 0;
        while (!(load_done === 1'b1 || load_error === 1'b1) && l < 40) begin
            @(negedge clk);
            l++;
        end
        total++;
        if (l >= 40) begin
            bad++;
            $display("FAIL load_finish: done=%b err=%b, required one of them within 40 cycles", load_done, load_error);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.Byte_In = 8'h00;
        bus.Byte_Valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.Byte_Ready, bus.IMEM_We, bus.IMEM_Addr, bus.IMEM_Wdata, cpu_hold, load_done, load_error, words_loaded} !== 74'd0) begin
            bad++;
            $display("FAIL reset_vals: got %h, required 0",
                     {bus.Byte_Ready, bus.IMEM_We, bus.IMEM_Addr, bus.IMEM_Wdata, cpu_hold, load_done, load_error, words_loaded});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input bit gaps);
        int b = we_cnt;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h00500093;
        exp_d[1] = 32'h00A00113;
        exp_d[2] = 32'h002081B3;
        for (int i = 0; i < 3; i++) img[i] = exp_d[i];
        load(32'd3, 3, gaps, lat);
        total++;
        if (we_cnt - b !== 3) begin
            bad++;
            $display("FAIL basic_we_count: got %0d, required 3", we_cnt - b);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (log_addr[b+i] !== 32'(i * 4) || log_data[b+i] !== exp_d[i]) begin
                bad++;
                $display("FAIL basic_write%0d: addr=%h data=%h, required addr=%h data=%h",
                         i, log_addr[b+i], log_data[b+i], 32'(i * 4), exp_d[i]);
            end
        end
        total++;
        if ({load_done, load_error, cpu_hold, words_loaded} !== 8'b100_00011) begin
            bad++;
            $display("FAIL basic_status: done/err/hold/wl=%b, required 10000011", {load_done, load_error, cpu_hold, words_loaded});
        end
        total++;
        if (mem[4'd1] !== 32'h00A00113) begin
            bad++;
            $display("FAIL basic_imem_read_pc4: got %h, required 00a00113", mem[4'd1]);
        end
        total++;
        if (rdy_viol !== 0) begin
            bad++;
            $display("FAIL ready_during_we: %0d write cycles with Byte_Ready high, required 0", rdy_viol);
        end
`ifndef IMEM_LOADER_CHECKSUM_EN
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL done_latency: %0d cycles after WRITE cycle, required 1", lat);
        end
`endif
    endtask

    task automatic test_overflow();
        int b = we_cnt;
        load(32'd17, 0, 1'b0, lat);
        total++;
        if (lat !== 0) begin
            bad++;
            $display("FAIL overflow_latency: got %0d, required 0", lat);
        end
        total++;
        if ({load_error, load_done, cpu_hold, bus.Byte_Ready} !== 4'b1010 || we_cnt !== b) begin
            bad++;
            $display("FAIL overflow_status: err/done/hold/rdy=%b writes=%0d, required 1010 and 0",
                     {load_error, load_done, cpu_hold, bus.Byte_Ready}, we_cnt - b);
        end
    endtask

    task automatic test_boundary();
        int b = we_cnt;
        for (int i = 0; i < 16; i++) img[i] = 32'hC0DE0000 | 32'(i);
        load(32'd16, 16, 1'b0, lat);
        total++;
        if (we_cnt - b !== 16 || log_addr[b+15] !== 32'h3C || log_data[b+15] !== 32'hC0DE000F || log_addr[b] !== 32'h0) begin
            bad++;
            $display("FAIL boundary_writes: n=%0d last addr=%h data=%h, required 16 at 0000003c c0de000f",
                     we_cnt - b, log_addr[b+15], log_data[b+15]);
        end
        total++;
        if ({load_done, load_error, cpu_hold, words_loaded} !== 8'b100_10000) begin
            bad++;
            $display("FAIL boundary_status: done/err/hold/wl=%b, required 10010000", {load_done, load_error, cpu_hold, words_loaded});
        end
        b = we_cnt;
        load(32'd0, 0, 1'b0, lat);
        total++;
        if ({load_done, load_error, cpu_hold, words_loaded} !== 8'b100_00000 || we_cnt !== b) begin
            bad++;
            $display("FAIL zero_len: done/err/hold/wl=%b writes=%0d, required 10000000 and 0",
                     {load_done, load_error, cpu_hold, words_loaded}, we_cnt - b);
        end
    endtask

    task automatic test_reset_mid();
        int b;
        for (int i = 0; i < 4; i++) img[i] = 32'h11110000 + 32'(i);
        start_load();
        send_word(32'd4, 1'b0);
        send_word(img[0], 1'b0);
        send_word(img[1], 1'b0);
        bus.Byte_Valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.Byte_Ready, bus.IMEM_We, bus.IMEM_Addr, bus.IMEM_Wdata, cpu_hold, load_done, load_error, words_loaded} !== 74'd0) begin
            bad++;
            $display("FAIL reset_mid_vals: got %h, required 0",
                     {bus.Byte_Ready, bus.IMEM_We, bus.IMEM_Addr, bus.IMEM_Wdata, cpu_hold, load_done, load_error, words_loaded});
        end
        rst_n = 1'b1;
        @(negedge clk);
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h0BADF00D;
        b = we_cnt;
        load(32'd2, 2, 1'b0, lat);
        total++;
        if (we_cnt - b !== 2 || log_addr[b+1] !== 32'h4 || log_data[b+1] !== 32'h0BADF00D || log_data[b] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL reset_mid_reload: n=%0d addr1=%h data0=%h data1=%h, required 2 00000004 deadbeef 0badf00d",
                     we_cnt - b, log_addr[b+1], log_data[b], log_data[b+1]);
        end
        total++;
        if ({load_done, load_error, cpu_hold, words_loaded} !== 8'b100_00010) begin
            bad++;
            $display("FAIL reset_mid_status: done/err/hold/wl=%b, required 10000010", {load_done, load_error, cpu_hold, words_loaded});
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        img[0] = 32'd1;
        img[1] = 32'd2;
        cs_adj = 32'd0;
        load(32'd2, 2, 1'b0, lat);
        total++;
        if ({load_done, load_error, cpu_hold} !== 3'b100) begin
            bad++;
            $display("FAIL csum_match: done/err/hold=%b, required 100", {load_done, load_error, cpu_hold});
        end
        cs_adj = 32'd1;
        load(32'd2, 2, 1'b0, lat);
        total++;
        if ({load_done, load_error, cpu_hold} !== 3'b011) begin
            bad++;
            $display("FAIL csum_mismatch: done/err/hold=%b, required 011", {load_done, load_error, cpu_hold});
        end
        cs_adj = 32'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_overflow();
        test_boundary();
        test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
